// File: rtl/bus_capture_pkg.sv
// Shared constants and helpers for the bus capture FIFO slice.
package bus_capture_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 4;

    // Value seen on an undriven bus because of the pull-ups.
    localparam logic [WIDTH_DEFAULT-1:0] FLOAT_VALUE = {WIDTH_DEFAULT{1'b1}};

    // Occupancy must be able to represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/capture_fifo_mem.sv
// Register-array storage for the capture FIFO: one write port, one asynchronous read port.
module capture_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     wrEn_i,
    input  logic [$clog2(DEPTH)-1:0] wrAddr_i,
    input  logic [WIDTH-1:0]         wrData_i,
    input  logic [$clog2(DEPTH)-1:0] rdAddr_i,
    output logic [WIDTH-1:0]         rdData_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately never cleared; occupancy tracking decides what is valid.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/bus_capture_fifo.sv
// Samples the shared bus on each strobe rising edge into a FWFT FIFO drained by valid/ready.
// Optional macro BUS_CAPTURE_FLOAT_CHECK_EN flags captures of an undriven bus instead of storing them.
module bus_capture_fifo
    import bus_capture_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                          port1,
    input  logic                          port2,
    input  logic [WIDTH-1:0]              port3,
    input  logic                          port4,
    input  logic                          port5,
    output logic [WIDTH-1:0]              port6,
    output logic                          port7,
    input  logic                          port8,
    output logic                          port9,
    output logic [count_width(DEPTH)-1:0] port10,
    output logic                          port11
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [WIDTH-1:0] FloatWord = {WIDTH{FLOAT_VALUE[0]}};

    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sPrev_q;
    logic             overflow_q, overflow_d;
    logic             captureEvt, captureOk, push, pop, headValid;
    logic [WIDTH-1:0] wrData, rdData;

    assign captureEvt = port5 & ~sPrev_q;
    assign headValid  = (count_q != '0);
    assign pop        = headValid & port8;

`ifdef BUS_CAPTURE_FLOAT_CHECK_EN
    logic floatErr_q;

    assign captureOk = captureEvt & ~port4;
    assign wrData    = port3;

    always_ff @(posedge port1) begin
        if (port2) begin
            floatErr_q <= 1'b0;
        end else if (captureEvt && port4) begin
            floatErr_q <= 1'b1;
        end
    end

    assign port11 = floatErr_q;
`else
    assign captureOk = captureEvt;
    assign wrData    = port4 ? FloatWord : port3;
    assign port11    = 1'b0;
`endif

    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    always_comb begin
        push       = captureOk & ((count_q != FullCount) | pop);
        overflow_d = overflow_q | (captureOk & (count_q == FullCount) & ~pop);
        wrPtr_d    = push ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d    = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge port1) begin
        if (port2) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            sPrev_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            sPrev_q    <= port5;
            overflow_q <= overflow_d;
        end
    end

    capture_fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i    (port1),
        .wrEn_i   (push & ~port2),
        .wrAddr_i (wrPtr_q),
        .wrData_i (wrData),
        .rdAddr_i (rdPtr_q),
        .rdData_o (rdData)
    );

    assign port6  = headValid ? rdData : '0;
    assign port7  = headValid;
    assign port9  = overflow_q;
    assign port10 = count_q;

endmodule

// File: tb/tb_bus_capture_fifo.sv
// Directed self-checking bench for bus_capture_fifo (default WIDTH=8, DEPTH=4).
// Honours BUS_CAPTURE_FLOAT_CHECK_EN to select the expected floating-bus behaviour.
module tb_bus_capture_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] busData;
    logic       busDis;
    logic       strobe;
    logic [7:0] headData;
    logic       headValid;
    logic       ready;
    logic       overflow;
    logic [2:0] count;
    logic       floatErr;

    int nAsserts = 0;
    int nFails   = 0;

    bus_capture_fifo #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .port1  (clk),
        .port2  (rst),
        .port3  (busData),
        .port4  (busDis),
        .port5  (strobe),
        .port6  (headData),
        .port7  (headValid),
        .port8  (ready),
        .port9  (overflow),
        .port10 (count),
        .port11 (floatErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe pulse: high for a cycle (capture on that edge), then low for a cycle.
    task automatic applyStimulus(input logic [7:0] data, input logic dis);
        busData = data;
        busDis  = dis;
        strobe  = 1'b1;
        tick();
        strobe  = 1'b0;
        tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        busData = 8'h00;
        busDis  = 1'b0;
        strobe  = 1'b0;
        ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        checkOutput("rst_valid", headValid, 0);
        checkOutput("rst_data", headData, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_float", floatErr, 0);

        // Single capture visible one cycle after the sampling edge
        busData = 8'hA5;
        strobe  = 1'b1;
        tick();
        checkOutput("cap_valid", headValid, 1);
        checkOutput("cap_data", headData, 8'hA5);
        checkOutput("cap_count", count, 1);
        strobe = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("cap_drained", count, 0);

        // Fill, overflow, then drain in order
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b0);
        checkOutput("full_count", count, 4);
        checkOutput("full_ovf", overflow, 0);
        applyStimulus(8'h05, 1'b0);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_count", count, 4);
        checkOutput("ovf_head", headData, 8'h01);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("drain_%0d", i), headData, i);
            tick();
        end
        ready = 1'b0;
        checkOutput("drain_valid", headValid, 0);
        checkOutput("drain_data", headData, 0);
        checkOutput("ovf_sticky", overflow, 1);

        // Push and pop together while full
        doReset();
        checkOutput("rst2_ovf", overflow, 0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        busData = 8'h77;
        strobe  = 1'b1;
        ready   = 1'b1;
        tick();
        strobe = 1'b0;
        ready  = 1'b0;
        checkOutput("pp_count", count, 4);
        checkOutput("pp_ovf", overflow, 0);
        checkOutput("pp_head", headData, 8'h22);
        tick();
        ready = 1'b1;
        checkOutput("pp_d0", headData, 8'h22);
        tick();
        checkOutput("pp_d1", headData, 8'h33);
        tick();
        checkOutput("pp_d2", headData, 8'h44);
        tick();
        checkOutput("pp_last", headData, 8'h77);
        tick();
        ready = 1'b0;
        checkOutput("pp_empty", headValid, 0);

        // Strobe held high through reset release must not capture
        strobe = 1'b1;
        busData = 8'h5A;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        checkOutput("hold_count", count, 0);
        strobe = 1'b0;
        tick();
        strobe = 1'b1;
        tick();
        checkOutput("hold_recap", count, 1);
        checkOutput("hold_data", headData, 8'h5A);
        strobe = 1'b0;
        ready  = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("hold_drained", count, 0);

        // Capture of an undriven bus
        applyStimulus(8'h3C, 1'b1);
`ifdef BUS_CAPTURE_FLOAT_CHECK_EN
        checkOutput("float_err", floatErr, 1);
        checkOutput("float_count", count, 0);
        checkOutput("float_ovf", overflow, 0);
`else
        checkOutput("float_err", floatErr, 0);
        checkOutput("float_count", count, 1);
        checkOutput("float_data", headData, 8'hFF);
        ready = 1'b1;
        tick();
        ready = 1'b0;
`endif
        busDis = 1'b0;

        // Reset with three entries buffered and a strobe edge in the same cycle
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(8'hC0 + 8'(i), 1'b0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("pre_rst_count", count, 3);
        checkOutput("pre_rst_ovf", overflow, 1);
        busData = 8'h99;
        strobe  = 1'b1;
        rst     = 1'b1;
        tick();
        rst    = 1'b0;
        strobe = 1'b0;
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_valid", headValid, 0);
        checkOutput("mid_rst_ovf", overflow, 0);
        checkOutput("mid_rst_data", headData, 0);
        tick();
        checkOutput("post_rst_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
